// File: rtl/adder_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the adder arbiter.
// Grants are sized for the largest supported requester count.
package adder_arb_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int TAG_W     = $clog2(N_REQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  // One-hot grant for the first asserted valid at or after ptr, wrapping at n.
  function automatic logic [N_REQ_MAX-1:0] rr_pick(
    input logic [N_REQ_MAX-1:0] valid,
    input tag_t                 ptr,
    input int                   n
  );
    logic [N_REQ_MAX-1:0] grant;
    logic                 found;
    int                   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx[TAG_W-1:0]]) begin
        grant[idx[TAG_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bundle: per-requester operand handshake and shared result bus.
// The arbiter is the slave; the operand sources are the master.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            req_cin;
  logic [N_REQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]            rsp_s;
  logic                        rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin,
    input  req_ready, rsp_valid, rsp_s, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    output req_ready, rsp_valid, rsp_s, rsp_cout
  );

endinterface

// File: rtl/adder_arbiter_tag_fifo.sv
// In-order tag FIFO remembering which requester issued each adder operation.
// Its occupancy doubles as the in-flight operation count.
module tag_fifo
  import adder_arb_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = tag_t
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between N_REQ requesters,
// tagging each issue so results return to the requester that sent them.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int MAX_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  adder_arbiter_if.slave           req_if,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic                     cin,
  output logic                     valid_in,
  input  logic [WIDTH-1:0]         s,
  input  logic                     cout,
  input  logic                     valid_out,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err
);

  tag_t                 rr_ptr_p0;
  tag_t                 rr_ptr_nxt;
  tag_t                 acc_tag;
  tag_t                 head_tag;
  logic [N_REQ_MAX-1:0] valid_pad;
  logic [N_REQ_MAX-1:0] grant_pad;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     rsp_hot;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;
  logic                 cin_sel;
  logic                 credit_ok;
  logic                 accept;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;

  always_comb begin
    valid_pad              = '0;
    valid_pad[N_REQ-1:0]   = req_if.req_valid;
    grant_pad              = rr_pick(valid_pad, rr_ptr_p0, N_REQ);
    grant                  = grant_pad[N_REQ-1:0];
  end

  // A full tag FIFO means MAX_OUT in flight; a same-cycle pop frees nothing yet.
  assign credit_ok        = rstn & ~fifo_full;
  assign req_if.req_ready = credit_ok ? grant : '0;
  assign accept           = |(req_if.req_valid & req_if.req_ready);

  always_comb begin
    a_sel      = '0;
    b_sel      = '0;
    cin_sel    = 1'b0;
    acc_tag    = '0;
    rr_ptr_nxt = rr_ptr_p0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_if.req_ready[i]) begin
        a_sel      = req_if.req_a[i];
        b_sel      = req_if.req_b[i];
        cin_sel    = req_if.req_cin[i];
        acc_tag    = tag_t'(i);
        rr_ptr_nxt = (i == N_REQ - 1) ? tag_t'(0) : tag_t'(i + 1);
      end
    end
  end

  // Issue stage: selected operands registered toward the adder
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_in  <= 1'b0;
      a         <= '0;
      b         <= '0;
      cin       <= 1'b0;
      rr_ptr_p0 <= '0;
    end else begin
      valid_in <= accept;
      if (accept) begin
        a         <= a_sel;
        b         <= b_sel;
        cin       <= cin_sel;
        rr_ptr_p0 <= rr_ptr_nxt;
      end
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUT),
    .T     (tag_t)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .din   (acc_tag),
    .pop   (pop),
    .head  (head_tag),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (outstanding)
  );

  assign pop = valid_out & ~fifo_empty;

  always_comb begin
    rsp_hot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_hot[i] = pop && (head_tag == tag_t'(i));
    end
  end

  // Response stage: adder result routed to the head tag's requester
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_if.rsp_valid <= '0;
      req_if.rsp_s     <= '0;
      req_if.rsp_cout  <= 1'b0;
      err              <= 1'b0;
    end else begin
      req_if.rsp_valid <= rsp_hot;
      if (pop) begin
        req_if.rsp_s    <= s;
        req_if.rsp_cout <= cout;
      end
      if (valid_out && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer sharing one pipelined 32-bit adder between `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's `a`/`b`/`cin`/`valid_in`. It records the issuing requester of each operation in an in-order tag FIFO and routes each `s`/`cout` result back to that requester. It sits between the operand sources (BRAM-fed test harnesses, compute units) and the single adder instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand/sum width.
- `MAX_OUT`, 8: maximum operations in flight; equals tag FIFO depth; power of 2, ≥ adder latency + 2 for full throughput.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has an operation.
- `req_ready`  out  N_REQ  operation of requester i accepted this cycle.
- `req_a`, `req_b`  in  N_REQ×WIDTH  operands per requester.
- `req_cin`  in  N_REQ  carry-in per requester.
- `a`, `b`  out  WIDTH  adder operands.
- `cin`  out  1  adder carry-in.
- `valid_in`  out  1  adder input valid.
- `s`  in  WIDTH  adder sum.
- `cout`  in  1  adder carry-out.
- `valid_out`  in  1  adder output valid, in issue order, cannot be stalled.
- `rsp_valid`  out  N_REQ  one-hot result pulse to requester i.
- `rsp_s`  out  WIDTH  result sum, shared by all requesters.
- `rsp_cout`  out  1  result carry, shared by all requesters.
- `outstanding`  out  $clog2(MAX_OUT)+1  operations in flight.
- `err`  out  1  sticky: `valid_out` seen with the tag FIFO empty.

## Operation
- Arbitration:
  - Combinational round-robin over `req_valid`, searching from `rr_ptr`.
  - `req_ready` is one-hot on the selected requester, or all zero.
  - `req_ready` is all zero when `outstanding == MAX_OUT`. A same-cycle `valid_out` does not free a credit that cycle.
- Accept = `req_valid[i] & req_ready[i]`. On accept:
  - Register `a`/`b`/`cin` from requester i.
  - Set `valid_in` = 1 for exactly one cycle.
  - Push tag i into the FIFO.
  - Set `rr_ptr` ← (i+1) mod N_REQ.
- No accept: `valid_in` ← 0. `a`/`b`/`cin` hold their values. `rr_ptr` holds.
- Result, on `valid_out` with the FIFO non-empty:
  - Pop head tag t.
  - Next cycle: `rsp_valid` = one-hot(t), `rsp_s` = `s`, `rsp_cout` = `cout`.
- Result, on `valid_out` with the FIFO empty: set `err` = 1. No response, no pop, counter unchanged.
- Counter:
  - `outstanding` +1 on accept, −1 on a valid pop.
  - Both in the same cycle: unchanged.
  - Never wraps; the credit gating guarantees this.
- Requesters must hold `req_valid` and operands stable until `req_ready`. Requesters must accept `rsp_valid` unconditionally; there is no backpressure on responses.

## Timing
- Reset values:
  - `req_ready` = 0 for the reset cycle only; it is combinational afterwards.
  - `valid_in` = 0, `a` = `b` = 0, `cin` = 0.
  - `rsp_valid` = 0, `rsp_s` = 0, `rsp_cout` = 0.
  - `outstanding` = 0, `err` = 0, `rr_ptr` = 0, FIFO empty.
- Issue latency: accept in cycle T → `valid_in` high in T+1.
- Response latency: `valid_out` in cycle U → `rsp_valid` high in U+1.
- End-to-end latency: adder latency + 2.
- Throughput: one operation per cycle while credits remain.
- Full FIFO with simultaneous accept and pop is impossible, because accept requires `outstanding < MAX_OUT`.
- Reset mid-operation: all state is cleared within one cycle. The adder shares `rstn` and flushes, so in-flight results are discarded. `err` is cleared.
- `rr_ptr` wraps from N_REQ−1 to 0.

## Structure
- Package `adder_arb_pkg`:
  - `tag_t` = logic [$clog2(N_REQ_MAX=8)−1:0].
  - `N_REQ_MAX`.
  - Function `rr_pick(valid, ptr)` returning a one-hot grant.
- Sub-module `tag_fifo`: synchronous FIFO parameterized by DEPTH and `tag_t`, with `push`, `pop`, `head`, `empty`, `full`, and count.
- The arbiter, counter and output registers live in `adder_arbiter`.

## Test plan
- Single op: requester 2 sends a=0x0000_0005, b=0x0000_0007, cin=0.
  - `valid_in` asserts the next cycle.
  - After adder latency + 2 cycles: `rsp_valid` = 4'b0100, `rsp_s` = 0x0000_000C, `rsp_cout` = 0.
- Fairness: all 4 requesters hold `req_valid` for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each result is routed to its own requester in issue order.
- Carry: requester 1 sends a=0xFFFF_FFFF, b=0x0000_0001, cin=0.
  - `rsp_s` = 0, `rsp_cout` = 1, `rsp_valid` = 4'b0010.
- Credit stall: MAX_OUT=8 with the adder outputs held off (latency stretched).
  - After 8 accepts, `req_ready` = 0 and `outstanding` = 8.
  - The first `valid_out` → `outstanding` = 7, and one accept is allowed the following cycle.
- Error and reset:
  - Inject `valid_out` with nothing issued → `err` = 1 and no `rsp_valid`.
  - Assert `rstn` = 0 with 3 ops in flight → next cycle `outstanding` = 0, `err` = 0, `valid_in` = 0, `rr_ptr` = 0.
